// File: rtl/cordic_vectoring.sv
`timescale 1ns/1ps
// Vectoring-mode CORDIC: (x_in, y_in) -> atan2(y,x) on angle_out and the vector magnitude on mag_out.
// Latency: valid pulses ITER+1 clocks after the accepted start edge (ITER+2 with CORDIC_VEC_GAIN_COMP_EN).
// Backpressure: none; start is sampled only in IDLE/DONE and is ignored while busy (no queuing).
//
// Ports: clk, reset_n (async active-low), start, x_in/y_in (signed Q2.30),
//        angle_out (signed Q3.29 rad), mag_out (unsigned Q2.30), busy, valid.
// Build option: CORDIC_VEC_GAIN_COMP_EN adds a GAIN cycle that scales the magnitude by K=0.60725;
//        without it mag_out is the raw CORDIC x (magnitude*1.64676), saturated to 0xFFFFFFFF.
module cordic_vectoring #(
    parameter int ITER = 16                     // micro-rotations, legal range 8..16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    output logic [31:0] angle_out,
    output logic [31:0] mag_out,
    output logic        busy,
    output logic        valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_GAIN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic signed [33:0] HALF_PI = 34'sh0_6487ED51;   // pi/2 in Q4.30
    localparam logic        [31:0] K_GAIN  = 32'h26DD3B6A;      // 1/1.64676 in Q2.30

    state_t state, state_nxt;

    logic signed [33:0] x_q, y_q, z_q;
    logic        [3:0]  i_q;
    logic               zero_q;         // (0,0) operand: the angle is forced to 0

    logic               accept;
    logic               last_step;

    logic signed [33:0] x_ext, y_ext;
    logic signed [33:0] x_pre, y_pre, z_pre;
    logic signed [33:0] x_step, y_step, z_step;
    logic signed [33:0] x_shr, y_shr, e_i;

    // arctan(2^-i) in Q2.30
    function automatic logic [31:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_lut = 32'h3243F6A9;
            4'd1:    atan_lut = 32'h1DAC6705;
            4'd2:    atan_lut = 32'h0FADBAFD;
            4'd3:    atan_lut = 32'h07F56EA7;
            4'd4:    atan_lut = 32'h03FEAB77;
            4'd5:    atan_lut = 32'h01FFD55C;
            4'd6:    atan_lut = 32'h00FFFAAB;
            4'd7:    atan_lut = 32'h007FFF55;
            4'd8:    atan_lut = 32'h003FFFEB;
            4'd9:    atan_lut = 32'h001FFFFD;
            4'd10:   atan_lut = 32'h00100000;
            4'd11:   atan_lut = 32'h00080000;
            4'd12:   atan_lut = 32'h00040000;
            4'd13:   atan_lut = 32'h00020000;
            4'd14:   atan_lut = 32'h00010000;
            default: atan_lut = 32'h00008000;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        last_step = (i_q == 4'(ITER - 1));
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_ITER;
                end
            end
            S_ITER: begin
                busy = 1'b1;
                if (last_step) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                    state_nxt = S_GAIN;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
            S_GAIN: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                // back-to-back restart is allowed straight out of DONE
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_ITER;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand load with quadrant pre-rotation into the right half-plane.
    // 34-bit width keeps -(-2^31) exact and leaves headroom for the
    // 1.647x CORDIC growth on a sqrt(2)*2 input.
    // ------------------------------------------------------------------
    always_comb begin
        x_ext = {{2{x_in[31]}}, x_in};
        y_ext = {{2{y_in[31]}}, y_in};
        x_pre = x_ext;
        y_pre = y_ext;
        z_pre = '0;
        if (x_in[31] && !y_in[31]) begin
            x_pre = y_ext;
            y_pre = -x_ext;
            z_pre = HALF_PI;
        end else if (x_in[31] && y_in[31]) begin
            x_pre = -y_ext;
            y_pre = x_ext;
            z_pre = -HALF_PI;
        end
    end

    // ------------------------------------------------------------------
    // One micro-rotation: drive y toward 0. x always grows by |y|>>>i,
    // and z accumulates the rotation applied.
    // ------------------------------------------------------------------
    always_comb begin
        x_shr = x_q >>> i_q;
        y_shr = y_q >>> i_q;
        e_i   = $signed({2'b00, atan_lut(i_q)});
        if (y_q[33]) begin
            x_step = x_q - y_shr;
            y_step = y_q + x_shr;
            z_step = z_q - e_i;
        end else begin
            x_step = x_q + y_shr;
            y_step = y_q - x_shr;
            z_step = z_q + e_i;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            i_q       <= '0;
            zero_q    <= 1'b0;
            angle_out <= '0;
            mag_out   <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;

            if (state == S_DONE) begin
                valid     <= 1'b1;
                angle_out <= zero_q ? 32'h0 : z_q[32:1];
`ifdef CORDIC_VEC_GAIN_COMP_EN
                mag_out   <= x_q[31:0];
`else
                mag_out   <= (x_q[33:32] != 2'b00) ? 32'hFFFFFFFF : x_q[31:0];
`endif
            end

            if (accept) begin
                x_q    <= x_pre;
                y_q    <= y_pre;
                z_q    <= z_pre;
                i_q    <= '0;
                zero_q <= (x_in == 32'h0) && (y_in == 32'h0);
            end else if (state == S_ITER) begin
                x_q <= x_step;
                y_q <= y_step;
                z_q <= z_step;
                i_q <= i_q + 4'd1;
            end
`ifdef CORDIC_VEC_GAIN_COMP_EN
            else if (state == S_GAIN) begin
                // x is non-negative here; the scaled result is <= 2.83 and fits Q2.30
                x_q <= $signed(34'((66'($unsigned(x_q)) * 66'(K_GAIN)) >> 30));
            end
`endif
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
`timescale 1ns/1ps
// Self-checking bench for cordic_vectoring: directed corner vectors, handshake
// corner cases, and randomized operands compared with a real-arithmetic atan2/sqrt model.
module tb_cordic_vectoring;

    localparam int ITER = 16;
`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam int LAT = ITER + 2;
`else
    localparam int LAT = ITER + 1;
`endif
    localparam int ANG_TOL = 32'h4000;
    localparam int MAG_TOL = 32'h40000;
    localparam int TMO     = 200;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [31:0] x_in    = '0;
    logic [31:0] y_in    = '0;
    logic [31:0] angle_out, mag_out;
    logic        busy, valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    cordic_vectoring #(.ITER(ITER)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .angle_out (angle_out),
        .mag_out   (mag_out),
        .busy      (busy),
        .valid     (valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp,
                       input int tol);
        longint d;
        total++;
        d = longint'($signed(got - exp));
        if (d < 0) d = -d;
        if (d > longint'(tol)) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h (tol %0h)", tag, got, exp, tol);
        end
    endtask

    // Reference: atan2 and Euclidean magnitude, scaled by the CORDIC gain of ITER steps.
    function automatic void model(input logic [31:0] xi, input logic [31:0] yi,
                                  output logic [31:0] ea, output logic [31:0] em);
        real xr, yr, a, m, g, p, raw;
        xr = $itor($signed(xi));
        yr = $itor($signed(yi));
        a  = (xi == 0 && yi == 0) ? 0.0 : $atan2(yr, xr);
        ea = 32'(longint'(a * 536870912.0));
        m  = $sqrt(xr * xr + yr * yr);
        g  = 1.0;
        p  = 1.0;
        for (int k = 0; k < ITER; k++) begin
            g = g * $sqrt(1.0 + p);
            p = p / 4.0;
        end
`ifdef CORDIC_VEC_GAIN_COMP_EN
        raw = m * g * ($itor(32'h26DD3B6A) / 1073741824.0);
`else
        raw = m * g;
`endif
        if (raw > 4294967295.0) em = 32'hFFFFFFFF;
        else                    em = 32'(longint'(raw));
    endfunction

    // Start one conversion and wait (bounded) for valid. lat counts clock edges after the accepting edge.
    task automatic run_conv(input logic [31:0] x, input logic [31:0] y,
                            output logic [31:0] ang, output logic [31:0] mag, output int lat,
                            output logic busy_mid, output logic busy_after);
        @(negedge clk);
        x_in  = x;
        y_in  = y;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        busy_mid = busy;
        lat      = 0;
        while (!valid && lat < TMO) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        ang        = angle_out;
        mag        = mag_out;
        busy_after = busy;
    endtask

    task automatic dir_case(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] ea_spec, input bit has_m, input logic [31:0] em_spec);
        logic [31:0] ang, mag, ea, em;
        logic        bm, ba;
        int          lat;
        model(x, y, ea, em);
        if (has_m) em = em_spec;
        run_conv(x, y, ang, mag, lat, bm, ba);
        chk({tag, "_ang"}, ang, ea_spec, ANG_TOL);
        chk({tag, "_mag"}, mag, em, MAG_TOL);
        chk({tag, "_lat"}, 32'(lat), 32'(LAT), 0);
        chk({tag, "_busy_mid"}, {31'b0, bm}, 32'h1, 0);
        chk({tag, "_busy_end"}, {31'b0, ba}, 32'h0, 0);
    endtask

    initial begin
        logic [31:0] ang, mag, ea, em, rx, ry;
        logic        bm, ba;
        int          lat, vcnt;
        int          vt[$];
        bit          macro_on;
`ifdef CORDIC_VEC_GAIN_COMP_EN
        macro_on = 1'b1;
`else
        macro_on = 1'b0;
`endif

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_angle", angle_out, 32'h0, 0);
        chk("rst_mag",   mag_out,   32'h0, 0);
        chk("rst_busy",  {31'b0, busy},  32'h0, 0);
        chk("rst_valid", {31'b0, valid}, 32'h0, 0);
        reset_n = 1'b1;

        // ---------------- directed vectors ----------------
        dir_case("t1_x1",   32'h40000000, 32'h00000000, 32'h00000000, 1'b1,
                 macro_on ? 32'h40000000 : 32'h69648534);
        dir_case("t2_py",   32'h00000000, 32'h40000000, 32'h3243F6A9, 1'b0, 32'h0);
        dir_case("t2_ny",   32'h00000000, 32'hC0000000, 32'hCDBC0957, 1'b0, 32'h0);
        dir_case("t3_nx",   32'hC0000000, 32'h00000000, 32'h6487ED51, 1'b0, 32'h0);
        dir_case("t3_nxny", 32'hC0000000, 32'hC0000000, 32'hB49A0E04, macro_on, 32'h5A82799A);
        dir_case("t4_sat",  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h1921FB54, !macro_on, 32'hFFFFFFFF);
        dir_case("zero",    32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000);
        dir_case("minneg",  32'h80000000, 32'h80000000, 32'hB49A0E04, 1'b0, 32'h0);

        // ---------------- start while busy is ignored ----------------
        model(32'h40000000, 32'h00000000, ea, em);
        @(negedge clk);
        x_in  = 32'h40000000;
        y_in  = 32'h00000000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        vcnt  = 0;
        ang   = '0;
        mag   = '0;
        for (int k = 1; k <= 3 * LAT; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 4) begin
                x_in  = 32'h00000000;
                y_in  = 32'h40000000;
                start = 1'b1;
            end
            if (k == 5) begin
                start = 1'b0;
                chk("ign_busy", {31'b0, busy}, 32'h1, 0);
            end
            if (valid) begin
                vcnt++;
                if (vcnt == 1) begin
                    ang = angle_out;
                    mag = mag_out;
                    chk("ign_lat", 32'(k), 32'(LAT), 0);
                end
            end
        end
        chk("ign_vcnt", 32'(vcnt), 32'h1, 0);
        chk("ign_ang",  ang, ea, ANG_TOL);
        chk("ign_mag",  mag, em, MAG_TOL);

        // ---------------- start held high re-triggers ----------------
        model(32'h20000000, 32'h30000000, ea, em);
        @(negedge clk);
        x_in  = 32'h20000000;
        y_in  = 32'h30000000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= 3 * LAT + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) begin
                vt.push_back(k);
                chk("retrig_ang", angle_out, ea, ANG_TOL);
            end
        end
        start = 1'b0;
        chk("retrig_cnt", 32'(vt.size()), 32'h3, 0);
        if (vt.size() >= 2) chk("retrig_gap", 32'(vt[1] - vt[0]), 32'(LAT), 0);
        repeat (2 * LAT) @(posedge clk);

        // ---------------- reset mid-iteration aborts ----------------
        run_conv(32'h00000000, 32'h40000000, ang, mag, lat, bm, ba);
        @(negedge clk);
        x_in  = 32'h20000000;
        y_in  = 32'hE0000000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_angle", angle_out, 32'h0, 0);
        chk("abort_mag",   mag_out,   32'h0, 0);
        chk("abort_busy",  {31'b0, busy}, 32'h0, 0);
        vcnt = 0;
        for (int k = 0; k < 3 + 2 * LAT; k++) begin
            @(negedge clk);
            if (k == 3) reset_n = 1'b1;
            if (valid) vcnt++;
        end
        chk("abort_novalid", 32'(vcnt), 32'h0, 0);
        model(32'h20000000, 32'hE0000000, ea, em);
        run_conv(32'h20000000, 32'hE0000000, ang, mag, lat, bm, ba);
        chk("post_rst_ang", ang, ea, ANG_TOL);
        chk("post_rst_mag", mag, em, MAG_TOL);
        chk("post_rst_lat", 32'(lat), 32'(LAT), 0);

        // ---------------- randomized operands ----------------
        for (int n = 0; n < 40; n++) begin
            rx = 32'($urandom_range(32'h3FFFFFFF, 32'h04000000));
            ry = 32'($urandom_range(32'h3FFFFFFF, 32'h04000000));
            if ($urandom_range(1, 0) == 1) rx = -rx;
            if ($urandom_range(1, 0) == 1) ry = -ry;
            model(rx, ry, ea, em);
            run_conv(rx, ry, ang, mag, lat, bm, ba);
            chk("rnd_ang", ang, ea, ANG_TOL);
            chk("rnd_mag", mag, em, MAG_TOL);
            chk("rnd_lat", 32'(lat), 32'(LAT), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
